// File: rtl/safety_input_conditioner_pkg.sv
// rtl/safety_input_conditioner_pkg.sv - shared types and default timing constants
package safety_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } blinker_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT      = 500000;
    localparam int unsigned BLINK_TIMEOUT_CYCLES_DEFAULT = 1500000000;

    // Press events outrank the timeout; simultaneous left+right presses cancel.
    function automatic blinker_state_t blinker_next(
        input blinker_state_t state,
        input logic           left_press,
        input logic           right_press,
        input logic           timeout
    );
        blinker_state_t nxt;
        nxt = state;
        if (left_press && right_press) begin
            nxt = OFF;
        end else if (left_press) begin
            nxt = (state == LEFT) ? OFF : LEFT;
        end else if (right_press) begin
            nxt = (state == RIGHT) ? OFF : RIGHT;
        end else if (timeout) begin
            nxt = OFF;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/safety_input_conditioner_if.sv
// rtl/safety_input_conditioner_if.sv - raw control inputs and conditioned requests
interface safety_input_conditioner_if;

    logic leftButtonRaw;
    logic rightButtonRaw;
    logic headLightButtonRaw;
    logic hornButtonRaw;
    logic brakeSwitchRaw;
    logic leftBlinker;
    logic rightBlinker;
    logic headLight;
    logic horn;
    logic brakes;

    modport master (
        output leftButtonRaw, rightButtonRaw, headLightButtonRaw, hornButtonRaw, brakeSwitchRaw,
        input  leftBlinker, rightBlinker, headLight, horn, brakes
    );

    modport slave (
        input  leftButtonRaw, rightButtonRaw, headLightButtonRaw, hornButtonRaw, brakeSwitchRaw,
        output leftBlinker, rightBlinker, headLight, horn, brakes
    );

endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronizer followed by a stable-count debouncer
module input_debouncer
    import safety_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          RESET_LEVEL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
            r_level <= RESET_LEVEL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/safety_input_conditioner.sv
// rtl/safety_input_conditioner.sv - debounces driver controls, latches headlight and blinker requests
module safety_input_conditioner
    import safety_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned BLINK_TIMEOUT_CYCLES = BLINK_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    safety_input_conditioner_if.slave    bus
);

    localparam logic [30:0] TIMEOUT_LAST = 31'(BLINK_TIMEOUT_CYCLES - 1);

    logic w_left_lvl, w_right_lvl, w_head_lvl, w_horn_lvl, w_brake_lvl;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_left_db (
        .i_clk(CLOCK_50), .i_reset(reset), .i_raw(bus.leftButtonRaw), .o_level(w_left_lvl));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_right_db (
        .i_clk(CLOCK_50), .i_reset(reset), .i_raw(bus.rightButtonRaw), .o_level(w_right_lvl));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_head_db (
        .i_clk(CLOCK_50), .i_reset(reset), .i_raw(bus.headLightButtonRaw), .o_level(w_head_lvl));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_horn_db (
        .i_clk(CLOCK_50), .i_reset(reset), .i_raw(bus.hornButtonRaw), .o_level(w_horn_lvl));
    // Brake switch is active-low, so it idles (and resets) high.
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_brake_db (
        .i_clk(CLOCK_50), .i_reset(reset), .i_raw(bus.brakeSwitchRaw), .o_level(w_brake_lvl));

    logic           r_left_prev, r_right_prev, r_head_prev;
    logic           w_left_press, w_right_press, w_head_press;
    logic           w_timeout;
    blinker_state_t r_state;
    blinker_state_t w_state_next;
    logic [30:0]    r_tcnt;
    logic           r_headlight;
    logic           r_left_blink;
    logic           r_right_blink;

    assign w_left_press  = w_left_lvl & ~r_left_prev;
    assign w_right_press = w_right_lvl & ~r_right_prev;
    assign w_head_press  = w_head_lvl & ~r_head_prev;
    assign w_timeout     = (r_state != OFF) && (r_tcnt == TIMEOUT_LAST);
    assign w_state_next  = blinker_next(r_state, w_left_press, w_right_press, w_timeout);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_left_prev   <= 1'b0;
            r_right_prev  <= 1'b0;
            r_head_prev   <= 1'b0;
            r_headlight   <= 1'b0;
            r_state       <= OFF;
            r_left_blink  <= 1'b0;
            r_right_blink <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            r_left_prev   <= w_left_lvl;
            r_right_prev  <= w_right_lvl;
            r_head_prev   <= w_head_lvl;
            if (w_head_press) begin
                r_headlight <= ~r_headlight;
            end
            r_state       <= w_state_next;
            r_left_blink  <= (w_state_next == LEFT);
            r_right_blink <= (w_state_next == RIGHT);
            if ((w_state_next != r_state) || (r_state == OFF)) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 31'd1;
            end
        end
    end

    assign bus.leftBlinker  = r_left_blink;
    assign bus.rightBlinker = r_right_blink;
    assign bus.headLight    = r_headlight;
    assign bus.horn         = w_horn_lvl;
    assign bus.brakes       = w_brake_lvl;

endmodule

// File: doc/safety_input_conditioner.md
SAFETY_INPUT_CONDITIONER -- requirements
Module: safety_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable cycles required before a debounced level changes (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter BLINK_TIMEOUT_CYCLES, default 1500000000, cycles an active blinker persists before auto-cancel (30 s); legal range 2..2^31-1.
REQ-003 Port CLOCK_50  input  1  sole clock; all flops on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports leftButtonRaw, rightButtonRaw, headLightButtonRaw, hornButtonRaw  input  1 each  asynchronous momentary buttons, 1 = pressed.
REQ-006 Port brakeSwitchRaw  input  1  asynchronous brake switch, 0 = braking.
REQ-007 Ports leftBlinker, rightBlinker  output  1 each  latched turn-signal requests, 1 = blink.
REQ-008 Port headLight  output  1  latched headlight request, 1 = on.
REQ-009 Port horn  output  1  momentary horn request, 1 = sound.
REQ-010 Port brakes  output  1  debounced brake level, 0 = braking.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized input SHALL feed a debouncer whose counter clears whenever sync equals debounced and increments otherwise; debounced flips on the edge where the counter would reach DEBOUNCE_CYCLES, and the counter clears.
REQ-013 A raw change at edge N, held stable, SHALL change debounced at edge N+2+DEBOUNCE_CYCLES; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change it.
REQ-014 horn and brakes SHALL equal their debounced levels directly (latency N+2+DEBOUNCE_CYCLES).
REQ-015 A press event SHALL be a single-cycle 0->1 transition of a debounced button level; releases generate no event.
REQ-016 headLight SHALL toggle on each headLight press event, one cycle after the event (latency N+3+DEBOUNCE_CYCLES).
REQ-017 Blinker FSM states OFF, LEFT, RIGHT; leftBlinker = (state==LEFT), rightBlinker = (state==RIGHT); never both 1.
REQ-018 Transitions on left press: OFF->LEFT, LEFT->OFF, RIGHT->LEFT; on right press: OFF->RIGHT, RIGHT->OFF, LEFT->RIGHT.
REQ-019 Left and right press events in the same cycle SHALL force OFF from any state.
REQ-020 A 31-bit timeout counter SHALL clear on every state change and in OFF, and increment in LEFT/RIGHT; on reaching BLINK_TIMEOUT_CYCLES-1 the FSM SHALL go to OFF next edge.
REQ-021 A press event in the same cycle as timeout SHALL take priority over the timeout.
REQ-022 Holding a button does not repeat events; a new event requires a debounced release then press.

Reset
REQ-023 On reset all synchronizer and debounced button flops SHALL be 0; brake synchronizer and debounced brake flops SHALL be 1.
REQ-024 On reset: leftBlinker=0, rightBlinker=0, headLight=0, horn=0, brakes=1, FSM=OFF, all counters 0.
REQ-025 Reset asserted mid-debounce or mid-blink SHALL discard partial counts; no press event SHALL be generated by the reset release itself.

Structure
REQ-026 Package safety_pkg SHALL hold the blinker_state_t enum (OFF, LEFT, RIGHT) and the default DEBOUNCE_CYCLES / BLINK_TIMEOUT_CYCLES constants.
REQ-027 One sub-module input_debouncer (synchronizer + debounce counter, parameters DEBOUNCE_CYCLES and RESET_LEVEL) SHALL be instantiated five times.
REQ-028 Edge detection, headlight toggle, blinker FSM and timeout counter SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4, BLINK_TIMEOUT_CYCLES=20)
REQ-029 Reset, then hornButtonRaw 0->1 at edge 10 held -> horn=1 from edge 16; 3-cycle pulse on hornButtonRaw -> horn stays 0.
REQ-030 Two clean headLight presses (each held 10, released 10 cycles) -> headLight 0->1 at edge N+7, back to 0 after second press.
REQ-031 Left press -> leftBlinker=1; right press -> rightBlinker=1, leftBlinker=0 same edge; right press -> both 0.
REQ-032 Left press then idle -> leftBlinker falls exactly 20 cycles after rising; right press landing on timeout cycle -> RIGHT.
REQ-033 Left and right raw rising same edge while in LEFT -> both 0 at edge N+7.
REQ-034 brakeSwitchRaw to 0 held, reset pulsed mid-debounce -> brakes=1 after reset, then 0 DEBOUNCE_CYCLES+2 cycles after reset deasserts.
